// File: rtl/shift_add_mult_n_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encodings,
// counter sizing and the operand/adder width compatibility check.
package shift_add_mult_n_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Counter must hold N without wrapping, hence one bit above clog2(N).
    function automatic int unsigned count_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    // The 2N-bit accumulation adder is built from whole K-bit blocks.
    function automatic bit width_ok(input int unsigned n, input int unsigned k);
        return ((2 * n) % k) == 0;
    endfunction

    localparam int unsigned N_DEFAULT       = 16;
    localparam int unsigned COUNT_W_DEFAULT = count_w(N_DEFAULT);

endpackage

// File: rtl/csa_n.sv
// Carry-select adder: W-bit sum built from K-bit blocks, each computed for both
// carry-in values and selected by the incoming block carry (RCA or CLA blocks).
module csa_n #(
    parameter int unsigned W          = 32,
    parameter int unsigned K          = 8,
    parameter int unsigned BLOCK_TYPE = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);

    localparam int unsigned NB = W / K;

    // Returns {carry_out, sum} of one K-bit block.
    function automatic logic [K:0] blk_add(input logic [K-1:0] x, input logic [K-1:0] y,
                                           input logic cin);
        logic [K:0]   cc;
        logic [K-1:0] gg;
        logic [K-1:0] pg;
        logic         pp;
        gg    = x & y;
        pg    = x ^ y;
        cc    = '0;
        cc[0] = cin;
        pp    = 1'b0;
        for (int i = 0; i < int'(K); i++) begin
            if (BLOCK_TYPE == 1) begin
                // Lookahead: every carry expanded directly from generate/propagate terms.
                cc[i+1] = gg[i];
                pp      = pg[i];
                for (int j = i - 1; j >= 0; j--) begin
                    cc[i+1] = cc[i+1] | (pp & gg[j]);
                    pp      = pp & pg[j];
                end
                cc[i+1] = cc[i+1] | (pp & cin);
            end else begin
                cc[i+1] = gg[i] | (pg[i] & cc[i]);
            end
        end
        return {cc[K], pg ^ cc[K-1:0]};
    endfunction

    logic [NB:0] c;
    assign c[0] = ci;

    for (genvar g = 0; g < int'(NB); g++) begin : g_blk
        logic [K:0] r0;
        logic [K:0] r1;
        assign r0 = blk_add(a[g*K +: K], b[g*K +: K], 1'b0);
        assign r1 = blk_add(a[g*K +: K], b[g*K +: K], 1'b1);
        assign sum[g*K +: K] = c[g] ? r1[K-1:0] : r0[K-1:0];
        assign c[g+1]        = c[g] ? r1[K]     : r0[K];
    end

    assign co = c[NB];

endmodule

// File: rtl/shift_add_mult_n.sv
// Sequential unsigned shift-add multiplier, one partial product per clock via csa_n.
// Build option: SHIFT_ADD_MULT_EARLY_TERM_EN finishes as soon as the multiplier drains to zero.
module shift_add_mult_n
    import shift_add_mult_n_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned K          = 8,
    parameter int unsigned BLOCK_TYPE = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int unsigned PW = 2 * N;
    localparam int unsigned CW = count_w(N);

    if (!width_ok(N, K)) begin : g_bad_k
        $error("shift_add_mult_n: 2N must be a multiple of K");
    end

    logic [1:0]    state,  state_nxt;
    logic [PW-1:0] mcand,  mcand_nxt;
    logic [N-1:0]  mplier, mplier_nxt;
    logic [PW-1:0] acc,    acc_nxt;
    logic [CW-1:0] count,  count_nxt;
    logic [PW-1:0] p_nxt;
    logic [PW-1:0] sum;
    logic          csa_co_unused;

    csa_n #(
        .W          (PW),
        .K          (K),
        .BLOCK_TYPE (BLOCK_TYPE)
    ) u_csa (
        .a   (acc),
        .b   (mcand),
        .ci  (1'b0),
        .sum (sum),
        .co  (csa_co_unused)
    );

    // Next-state, datapath and product update.
    always_comb begin
        state_nxt  = state;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc;
        count_nxt  = count;
        p_nxt      = p;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    mcand_nxt  = PW'(a);
                    mplier_nxt = b;
                    acc_nxt    = '0;
                    count_nxt  = '0;
                    state_nxt  = RUN;
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                acc_nxt    = mplier[0] ? sum : acc;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                count_nxt  = count + CW'(1);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
                if (count == CW'(N - 1) || mplier_nxt == '0) begin
`else
                if (count == CW'(N - 1)) begin
`endif
                    state_nxt = DONE;
                    p_nxt     = acc_nxt;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            p      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            acc    <= acc_nxt;
            count  <= count_nxt;
            p      <= p_nxt;
            busy   <= (state_nxt == RUN);
            done   <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_shift_add_mult_n.sv
// Randomized self-checking bench for shift_add_mult_n (RCA and CLA adder builds side by side).
// Honours SHIFT_ADD_MULT_EARLY_TERM_EN for expected latency.
module tb_shift_add_mult_n;

    localparam int unsigned N = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          busy,   busy_c;
    logic          done,   done_c;
    logic [2*N-1:0] p,     p_c;

    int checks;
    int errors;

    shift_add_mult_n #(.N(N), .K(8), .BLOCK_TYPE(0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    shift_add_mult_n #(.N(N), .K(8), .BLOCK_TYPE(1)) u_dut_cla (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy_c),
        .done  (done_c),
        .p     (p_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RUN edges a multiplier value needs before the product is final.
    function automatic int run_edges(input logic [N-1:0] m);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i]) return i + 1;
        end
        return 1;
`else
        return N;
`endif
    endfunction

    // Present operands with start for one edge, then scramble the inputs.
    task automatic launch(input logic [N-1:0] ta, input logic [N-1:0] tb);
        a     = ta;
        b     = tb;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
    endtask

    // Follow an accepted operation to its done pulse; optionally poke start mid-run.
    task automatic wait_done(input logic [2*N-1:0] exp_p, input int exp_run, input int poke_cyc);
        int cycles;
        int busy_n;
        bit seen;
        cycles = 1;
        busy_n = 0;
        seen   = 1'b0;
        while (cycles <= exp_run + 5) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_n++;
            if (cycles == poke_cyc) begin
                start = 1'b1;
                a     = 16'd2;
                b     = 16'd2;
            end
            tick();
            start = 1'b0;
            cycles++;
        end
        check("done_seen",   64'(seen), 64'd1);
        check("latency",     64'(cycles), 64'(exp_run + 1));
        check("busy_cycles", 64'(busy_n), 64'(exp_run));
        check("busy_in_done", 64'(busy), 64'd0);
        check("product",     64'(p),   64'(exp_p));
        check("product_cla", 64'(p_c), 64'(exp_p));
        check("done_cla",    64'(done_c), 64'd1);
    endtask

    // One cycle after DONE with no start: idle, pulse over, product held.
    task automatic post_idle(input logic [2*N-1:0] exp_p);
        start = 1'b0;
        tick();
        check("done_pulse_end", 64'({done, done_c}), 64'd0);
        check("idle_busy",      64'({busy, busy_c}), 64'd0);
        check("p_held",         64'(p), 64'(exp_p));
    endtask

    task automatic mult(input logic [N-1:0] ta, input logic [N-1:0] tb, input int poke_cyc);
        logic [2*N-1:0] exp_p;
        exp_p = (2*N)'(ta) * (2*N)'(tb);
        launch(ta, tb);
        wait_done(exp_p, run_edges(tb), poke_cyc);
        post_idle(exp_p);
    endtask

    initial begin
        logic [N-1:0]   ra, rb;
        logic [2*N-1:0] last_p;
        int             dn;
        bit             in_done;

        checks = 0;
        errors = 0;

        // Reset hold with random inputs toggling.
        rst_n = 1'b0;
        repeat (2) begin
            start = 1'($urandom);
            a     = N'($urandom);
            b     = N'($urandom);
            tick();
        end
        check("rst_busy", 64'({busy, busy_c}), 64'd0);
        check("rst_done", 64'({done, done_c}), 64'd0);
        check("rst_p",    64'(p),   64'd0);
        check("rst_p_cla", 64'(p_c), 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();

        mult(16'd3, 16'd5, 0);
        mult(16'hFFFF, 16'hFFFF, 0);
        check("max_exact", 64'(p), 64'h0000_0000_FFFE_0001);

        // Start during RUN must be ignored.
        mult(16'd7, 16'd9, (run_edges(16'd9) < 5) ? run_edges(16'd9) : 5);

        // Reset mid-run abandons the operation without a done pulse.
        launch(16'd100, 16'd200);
        repeat (7) tick();
        check("midrun_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", 64'({busy, busy_c}), 64'd0);
        check("abort_done", 64'({done, done_c}), 64'd0);
        check("abort_p",    64'(p), 64'd0);
        dn = 0;
        repeat (20) begin
            tick();
            if (done || done_c || busy) dn++;
        end
        check("abort_quiet", 64'(dn), 64'd0);
        mult(16'd4, 16'd4, 0);

        // Latency extremes and zero operands.
        mult(16'd1234, 16'd1, 0);
        mult(16'd1234, 16'h8000, 0);
        check("shift15", 64'(p), 64'(32'd1234 << 15));
        mult(16'd55, 16'd0, 0);
        mult(16'd0, 16'hABCD, 0);

        // Back-to-back: start accepted while in DONE.
        launch(16'd11, 16'd13);
        wait_done(32'd143, run_edges(16'd13), 0);
        launch(16'd21, 16'd1000);
        wait_done(32'd21000, run_edges(16'd1000), 0);
        post_idle(32'd21000);

        // Random operations, some chained directly from DONE.
        in_done = 1'b0;
        last_p  = 32'd21000;
        for (int i = 0; i < 24; i++) begin
            ra = N'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 255)) : N'($urandom);
            if (!in_done && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 3)) tick();
                check("idle_p_hold", 64'(p), 64'(last_p));
            end
            launch(ra, rb);
            last_p = (2*N)'(ra) * (2*N)'(rb);
            wait_done(last_p, run_edges(rb), 0);
            in_done = ($urandom_range(0, 1) == 1);
            if (!in_done) post_idle(last_p);
        end
        if (in_done) post_idle(last_p);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_add_mult_n.md
Name: shift_add_mult_n

Overview:
Sequential unsigned shift-add multiplier. It is the direct consumer of the team's carry-select adder `csa_n`: one `csa_n` instance performs one partial-product accumulation per clock. It replaces an area-heavy array multiplier where throughput of one product per N+1 cycles is acceptable, and feeds downstream logic through a start/done handshake.

Parameters:
- N, 16, operand width. Product is 2N bits.
- K, 8, block size passed to the internal `csa_n`. 2N must be divisible by K.
- BLOCK_TYPE, 0, passed to `csa_n`: 0 = RCA blocks, 1 = CLA blocks.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  N  multiplicand; captured on the accepting edge.
- b  in  N  multiplier; captured on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; product valid.
- p  out  2N  product; held until the next accepted start.

Behaviour:
- Reset (rst_n low at an edge) forces:
  - state = IDLE, busy = 0, done = 0, p = 0;
  - internal mcand, mplier, acc and count = 0.
- Reset applies in any state, including mid-RUN. The abandoned operation never produces done.
- States: IDLE, RUN, DONE.
  - IDLE/DONE with start = 1: load mcand = zero-extended a (2N bits), mplier = b, acc = 0, count = 0; go to RUN.
  - DONE with start = 0: go to IDLE. done is high only while in DONE, so it lasts exactly one cycle.
  - RUN, each edge:
    - acc <= mplier[0] ? sum : acc, where sum = `csa_n`(acc, mcand, ci = 0) at 2N width. Carry-out is ignored; overflow is impossible.
    - mcand <= mcand << 1; mplier <= mplier >> 1; count <= count + 1.
    - When count reaches N-1 on this edge, go to DONE and load p with the final acc.
- Latency: start accepted at edge E; done observed high after edge E+N (N RUN edges, then DONE). In other words, done is high N+1 cycles after the accepting edge.
- start while busy is ignored. Operands are not re-sampled and the result is unaffected.
- Back-to-back operation: start high in DONE is accepted. done still pulses for that cycle, and the next RUN begins.
- a = 0 or b = 0 still takes the full latency (unless the optional feature is enabled) and yields p = 0.
- p changes only on the DONE-entry edge or on reset. It is not cleared on a new start.
- count is ceil(log2(N))+1 bits wide; it never wraps within an operation.

Optional Feature:
- Macro: SHIFT_ADD_MULT_EARLY_TERM_EN.
- Defined: in RUN, if the next mplier value (after the shift) is 0, go to DONE immediately and load p with the updated acc. Minimum latency is 2 cycles (one RUN edge, then DONE). Results are identical to the full-latency case.
- Undefined: fixed latency of exactly N RUN cycles regardless of operand values.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  - a localparam for count width;
  - a compile-time check that (2N) % K == 0.
- One sub-module instance: `csa_n` #(2N, K, BLOCK_TYPE) as the accumulation adder. The FSM and shift registers stay in this module; no new sub-module is needed.

Test Plan:
1. Reset hold: rst_n = 0 for 2 cycles with random a/b/start -> busy = 0, done = 0, p = 32'h0.
2. N = 16, a = 3, b = 5, start pulse -> done high exactly 17 cycles after the accepting edge, p = 32'd15, busy high for 16 cycles.
3. a = 16'hFFFF, b = 16'hFFFF -> p = 32'hFFFE0001; repeat with BLOCK_TYPE = 1 -> identical result and timing.
4. a = 7, b = 9 accepted; at RUN cycle 5 drive start with a = 2, b = 2 -> ignored; p = 32'd63 and a single done pulse.
5. a = 100, b = 200; rst_n low for 1 cycle at RUN cycle 8 -> next cycle busy = 0, p = 0, no done pulse; a fresh start with a = 4, b = 4 -> p = 16.
6. With SHIFT_ADD_MULT_EARLY_TERM_EN: a = 1234, b = 1 -> done after 2 cycles, p = 1234; b = 16'h8000 -> full 17 cycles, p = 1234 << 15. Without the macro, both cases take 17 cycles.
